// File: rtl/xillybus_stream_bridge.sv
// Bridge between a Xillybus write/read stream pair and an HLS ap_fifo core: a FWFT buffer
// towards the core, a 1-cycle-latency buffer towards the host, core reset and EOF generation.
module xillybus_stream_bridge #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 9,
   parameter int unsigned DRAIN_CYCLES = 64
) (
   input  logic              bus_clk,
   input  logic              ap_rst,
   input  logic              user_w_data_wren,
   input  logic [DATA_W-1:0] user_w_data_data,
   output logic              user_w_data_full,
   input  logic              user_w_data_open,
   input  logic              user_r_data_rden,
   output logic [DATA_W-1:0] user_r_data_data,
   output logic              user_r_data_empty,
   output logic              user_r_data_eof,
   input  logic              user_r_data_open,
   output logic              core_rst,
   output logic [DATA_W-1:0] in_r_dout,
   output logic              in_r_empty_n,
   input  logic              in_r_read,
   input  logic [DATA_W-1:0] out_r_din,
   output logic              out_r_full_n,
   input  logic              out_r_write,
   output logic [ADDR_W:0]   to_core_level,
   output logic [ADDR_W:0]   from_core_level
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StStream, StDrain, StEof} state_e;

   logic [DATA_W-1:0] a_mem [DEPTH];
   logic [DATA_W-1:0] b_mem [DEPTH];
   logic [DATA_W-1:0] a_ram_rdata;

   // A keeps three pointers: write, RAM fetch, and consumer (advances only when the core
   // reads), so full/level account for the words staged in the fetch and output registers.
   logic [ADDR_W:0]   a_wr_q, a_wr_d, a_rd_q, a_rd_d, a_cons_q, a_cons_d;
   logic              a_mid_valid_q, a_mid_valid_d, a_out_valid_q, a_out_valid_d;
   logic [DATA_W-1:0] a_out_q, a_out_d;
   logic [ADDR_W:0]   a_level_q, a_level_d;
   logic              a_full, a_push, a_pop, a_load, a_fetch;

   logic [ADDR_W:0]   b_wr_q, b_wr_d, b_rd_q, b_rd_d;
   logic [DATA_W-1:0] b_data_q, b_data_d;
   logic [ADDR_W:0]   b_level_q, b_level_d;
   logic              b_full, b_empty, b_empty_d, b_push, b_pop;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              eof_q, eof_d, core_rst_q, core_rst_d, drain_idle;

   always_comb begin
      a_full  = (a_wr_q[ADDR_W] != a_cons_q[ADDR_W]) &&
                (a_wr_q[ADDR_W-1:0] == a_cons_q[ADDR_W-1:0]);
      a_push  = user_w_data_open && user_w_data_wren && !a_full;
      a_pop   = user_w_data_open && in_r_read && a_out_valid_q;
      a_load  = user_w_data_open && a_mid_valid_q && (!a_out_valid_q || a_pop);
      a_fetch = user_w_data_open && (a_rd_q != a_wr_q) && (!a_mid_valid_q || a_load);

      a_wr_d        = a_wr_q + {{ADDR_W{1'b0}}, a_push};
      a_rd_d        = a_rd_q + {{ADDR_W{1'b0}}, a_fetch};
      a_cons_d      = a_cons_q + {{ADDR_W{1'b0}}, a_pop};
      a_mid_valid_d = a_fetch || (a_mid_valid_q && !a_load);
      a_out_valid_d = a_load || (a_out_valid_q && !a_pop);
      a_out_d       = a_load ? a_ram_rdata : a_out_q;
      if (!user_w_data_open) begin
         a_wr_d        = '0;
         a_rd_d        = '0;
         a_cons_d      = '0;
         a_mid_valid_d = 1'b0;
         a_out_valid_d = 1'b0;
      end
      a_level_d = a_wr_d - a_cons_d;
   end

   always_comb begin
      b_full  = (b_wr_q[ADDR_W] != b_rd_q[ADDR_W]) &&
                (b_wr_q[ADDR_W-1:0] == b_rd_q[ADDR_W-1:0]);
      b_empty = (b_wr_q == b_rd_q);
      b_push  = user_r_data_open && out_r_write && !b_full;
      b_pop   = user_r_data_open && user_r_data_rden && !b_empty;

      b_wr_d   = b_wr_q + {{ADDR_W{1'b0}}, b_push};
      b_rd_d   = b_rd_q + {{ADDR_W{1'b0}}, b_pop};
      b_data_d = b_pop ? b_mem[b_rd_q[ADDR_W-1:0]] : b_data_q;
      if (!user_r_data_open) begin
         b_wr_d = '0;
         b_rd_d = '0;
      end
      b_level_d = b_wr_d - b_rd_d;
      b_empty_d = (b_wr_d == b_rd_d);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      drain_idle = (a_wr_q == a_cons_q) && b_empty && !out_r_write;
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (user_w_data_open && user_r_data_open) state_d = StStream;
         end
         StStream: begin
            cnt_d = '0;
            if (!user_w_data_open) state_d = StDrain;
         end
         StDrain: begin
            if (user_w_data_open) begin
               state_d = StStream;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(DRAIN_CYCLES)) begin
               state_d = StEof;
            end else if (drain_idle) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = '0;
            end
         end
         default: state_d = StEof;
      endcase
      if (!user_r_data_open) begin
         state_d = StIdle;
         cnt_d   = '0;
      end
      // Uses next-state B occupancy so EOF never overlaps a word just written by the core.
      eof_d      = (state_d == StEof) && b_empty_d;
      core_rst_d = !user_r_data_open || (state_q == StIdle && !user_w_data_open);
   end

   always_ff @(posedge bus_clk) begin
      if (a_push)  a_mem[a_wr_q[ADDR_W-1:0]] <= user_w_data_data;
      if (a_fetch) a_ram_rdata <= a_mem[a_rd_q[ADDR_W-1:0]];
      if (b_push)  b_mem[b_wr_q[ADDR_W-1:0]] <= out_r_din;
   end

   always_ff @(posedge bus_clk or posedge ap_rst) begin
      if (ap_rst) begin
         a_wr_q        <= '0;
         a_rd_q        <= '0;
         a_cons_q      <= '0;
         a_mid_valid_q <= 1'b0;
         a_out_valid_q <= 1'b0;
         a_out_q       <= '0;
         a_level_q     <= '0;
         b_wr_q        <= '0;
         b_rd_q        <= '0;
         b_data_q      <= '0;
         b_level_q     <= '0;
         state_q       <= StIdle;
         cnt_q         <= '0;
         eof_q         <= 1'b0;
         core_rst_q    <= 1'b1;
      end else begin
         a_wr_q        <= a_wr_d;
         a_rd_q        <= a_rd_d;
         a_cons_q      <= a_cons_d;
         a_mid_valid_q <= a_mid_valid_d;
         a_out_valid_q <= a_out_valid_d;
         a_out_q       <= a_out_d;
         a_level_q     <= a_level_d;
         b_wr_q        <= b_wr_d;
         b_rd_q        <= b_rd_d;
         b_data_q      <= b_data_d;
         b_level_q     <= b_level_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         eof_q         <= eof_d;
         core_rst_q    <= core_rst_d;
      end
   end

   assign user_w_data_full  = a_full;
   assign in_r_dout         = a_out_q;
   assign in_r_empty_n      = a_out_valid_q;
   assign to_core_level     = a_level_q;
   assign user_r_data_data  = b_data_q;
   assign user_r_data_empty = b_empty;
   assign out_r_full_n      = !b_full;
   assign from_core_level   = b_level_q;
   assign user_r_data_eof   = eof_q;
   assign core_rst          = core_rst_q;

endmodule

// File: tb/tb_xillybus_stream_bridge.sv
// Self-checking bench for xillybus_stream_bridge: vector table for the FWFT path, queue
// scoreboards for both buffers, and hand-written sequences for drain/EOF and reset.
module tb_xillybus_stream_bridge;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 9;
   localparam int unsigned DEPTH = 2 ** AW;

   logic          bus_clk = 1'b0;
   logic          ap_rst;
   logic          user_w_data_wren, user_w_data_full, user_w_data_open;
   logic [DW-1:0] user_w_data_data;
   logic          user_r_data_rden, user_r_data_empty, user_r_data_eof, user_r_data_open;
   logic [DW-1:0] user_r_data_data;
   logic          core_rst, in_r_empty_n, in_r_read, out_r_full_n, out_r_write;
   logic [DW-1:0] in_r_dout, out_r_din;
   logic [AW:0]   to_core_level, from_core_level;

   xillybus_stream_bridge #(.DATA_W(DW), .ADDR_W(AW), .DRAIN_CYCLES(64)) dut (
      .bus_clk          (bus_clk),
      .ap_rst           (ap_rst),
      .user_w_data_wren (user_w_data_wren),
      .user_w_data_data (user_w_data_data),
      .user_w_data_full (user_w_data_full),
      .user_w_data_open (user_w_data_open),
      .user_r_data_rden (user_r_data_rden),
      .user_r_data_data (user_r_data_data),
      .user_r_data_empty(user_r_data_empty),
      .user_r_data_eof  (user_r_data_eof),
      .user_r_data_open (user_r_data_open),
      .core_rst         (core_rst),
      .in_r_dout        (in_r_dout),
      .in_r_empty_n     (in_r_empty_n),
      .in_r_read        (in_r_read),
      .out_r_din        (out_r_din),
      .out_r_full_n     (out_r_full_n),
      .out_r_write      (out_r_write),
      .to_core_level    (to_core_level),
      .from_core_level  (from_core_level)
   );

   always #5 bus_clk = ~bus_clk;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] q_a[$];
   logic [DW-1:0] q_b[$];

   typedef struct {
      logic          wren;
      logic [DW-1:0] wdata;
      logic          exp_valid;
      logic [DW-1:0] exp_dout;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: scoreboard bookkeeping from pre-edge values, edge, then post-edge checks.
   task automatic tick();
      logic          acc_a, acc_b, pop_b;
      logic [DW-1:0] exp_b;
      acc_a = user_w_data_wren && (q_a.size() < DEPTH);
      acc_b = out_r_write && (q_b.size() < DEPTH);
      pop_b = user_r_data_rden && (q_b.size() != 0) && user_r_data_open;
      exp_b = '0;
      if (user_w_data_open && in_r_read && in_r_empty_n) begin
         if (q_a.size() == 0) chk("a_unexpected_word", in_r_dout, 32'hxxxxxxxx);
         else chk("a_sb_data", in_r_dout, q_a.pop_front());
      end
      if (pop_b) exp_b = q_b.pop_front();
      if (!user_w_data_open) q_a.delete();
      else if (acc_a) q_a.push_back(user_w_data_data);
      if (!user_r_data_open) q_b.delete();
      else if (acc_b) q_b.push_back(out_r_din);
      @(posedge bus_clk);
      #1;
      if (pop_b) chk("b_sb_data", user_r_data_data, exp_b);
   endtask

   // EOF must stay low for 63 cycles after the idle period starts and be high by cycle 65.
   task automatic expect_eof_after(input string name);
      for (int i = 1; i <= 65; i++) begin
         tick();
         if (i <= 63) chk({name, "_eof_early"}, 32'(user_r_data_eof), 32'd0);
      end
      chk({name, "_eof_set"}, 32'(user_r_data_eof), 32'd1);
      chk({name, "_eof_empty"}, 32'(user_r_data_empty), 32'd1);
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h1, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 32'h2, 1'b0, 32'h0};
      vecs[2] = '{1'b1, 32'h3, 1'b1, 32'h1};
      vecs[3] = '{1'b1, 32'h4, 1'b1, 32'h2};
      vecs[4] = '{1'b0, 32'h0, 1'b1, 32'h3};
      vecs[5] = '{1'b0, 32'h0, 1'b1, 32'h4};
      vecs[6] = '{1'b0, 32'h0, 1'b0, 32'h0};

      ap_rst = 1'b1;
      user_w_data_wren = 1'b0; user_w_data_data = '0; user_w_data_open = 1'b0;
      user_r_data_rden = 1'b0; user_r_data_open = 1'b0;
      in_r_read = 1'b0; out_r_write = 1'b0; out_r_din = '0;
      #12 ap_rst = 1'b0;

      chk("rst_w_full", 32'(user_w_data_full), 32'd0);
      chk("rst_r_empty", 32'(user_r_data_empty), 32'd1);
      chk("rst_empty_n", 32'(in_r_empty_n), 32'd0);
      chk("rst_full_n", 32'(out_r_full_n), 32'd1);
      chk("rst_eof", 32'(user_r_data_eof), 32'd0);
      chk("rst_core_rst", 32'(core_rst), 32'd1);
      chk("rst_to_level", 32'(to_core_level), 32'd0);
      chk("rst_from_level", 32'(from_core_level), 32'd0);
      chk("rst_r_data", user_r_data_data, 32'd0);

      user_w_data_open = 1'b1; user_r_data_open = 1'b1;
      tick();
      chk("open_core_rst", 32'(core_rst), 32'd0);
      tick();

      // FWFT streaming with the core reading continuously
      in_r_read = 1'b1;
      for (int k = 0; k < 7; k++) begin
         user_w_data_wren = vecs[k].wren;
         user_w_data_data = vecs[k].wdata;
         tick();
         chk($sformatf("t1_valid_%0d", k), 32'(in_r_empty_n), 32'(vecs[k].exp_valid));
         if (vecs[k].exp_valid) chk($sformatf("t1_dout_%0d", k), in_r_dout, vecs[k].exp_dout);
      end
      in_r_read = 1'b0;

      // Fill A past capacity with the core idle
      for (int i = 0; i < DEPTH + 2; i++) begin
         chk("t2_full_track", 32'(user_w_data_full), 32'(q_a.size() == DEPTH));
         user_w_data_wren = 1'b1;
         user_w_data_data = 32'(i + 100);
         tick();
      end
      user_w_data_wren = 1'b0;
      chk("t2_full", 32'(user_w_data_full), 32'd1);
      chk("t2_level", 32'(to_core_level), DEPTH);
      chk("t2_model_size", q_a.size(), DEPTH);
      in_r_read = 1'b1;
      repeat (DEPTH + 6) tick();
      in_r_read = 1'b0;
      chk("t2_drained", q_a.size(), 32'd0);
      chk("t2_empty_n", 32'(in_r_empty_n), 32'd0);
      chk("t2_level0", 32'(to_core_level), 32'd0);

      // Core -> host path
      out_r_write = 1'b1; out_r_din = 32'hA5A5A5A5;
      tick();
      out_r_din = 32'h5A5A5A5A;
      tick();
      out_r_write = 1'b0;
      chk("t3_level", 32'(from_core_level), 32'd2);
      chk("t3_not_empty", 32'(user_r_data_empty), 32'd0);
      user_r_data_rden = 1'b1;
      tick();
      chk("t3_first", user_r_data_data, 32'hA5A5A5A5);
      tick();
      chk("t3_second", user_r_data_data, 32'h5A5A5A5A);
      chk("t3_empty", 32'(user_r_data_empty), 32'd1);
      tick();
      user_r_data_rden = 1'b0;
      chk("t3_hold", user_r_data_data, 32'h5A5A5A5A);

      // Host closes writes with three results still in the core
      user_w_data_open = 1'b0;
      tick();
      repeat (10) begin
         tick();
         chk("t4_no_eof_wait", 32'(user_r_data_eof), 32'd0);
      end
      out_r_write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         out_r_din = 32'(32'hC0DE0000 + i);
         tick();
      end
      out_r_write = 1'b0;
      repeat (5) begin
         tick();
         chk("t4_no_eof_data", 32'(user_r_data_eof), 32'd0);
      end
      chk("t4_core_rst", 32'(core_rst), 32'd0);
      user_r_data_rden = 1'b1;
      repeat (3) tick();
      user_r_data_rden = 1'b0;
      expect_eof_after("t4");
      user_w_data_open = 1'b1;
      repeat (3) tick();
      chk("t4_eof_sticky", 32'(user_r_data_eof), 32'd1);
      user_r_data_open = 1'b0;
      tick();
      chk("t4_close_eof", 32'(user_r_data_eof), 32'd0);
      chk("t4_close_rst", 32'(core_rst), 32'd1);
      user_r_data_open = 1'b1;
      repeat (2) tick();

      // Reopen during drain at counter 30
      user_w_data_open = 1'b0;
      tick();
      repeat (30) tick();
      user_w_data_open = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         chk("t5_eof", 32'(user_r_data_eof), 32'd0);
         chk("t5_core_rst", 32'(core_rst), 32'd0);
      end
      user_w_data_open = 1'b0;
      tick();
      expect_eof_after("t5");
      user_r_data_open = 1'b0;
      tick();
      user_r_data_open = 1'b1; user_w_data_open = 1'b1;
      repeat (2) tick();

      // Asynchronous reset with data in both buffers
      user_w_data_wren = 1'b1; out_r_write = 1'b1;
      for (int i = 0; i < 5; i++) begin
         user_w_data_data = 32'(i + 32'h300);
         out_r_din = 32'(i + 32'h400);
         tick();
      end
      user_w_data_wren = 1'b0; out_r_write = 1'b0;
      tick();
      chk("t6_pre_to", 32'(to_core_level), q_a.size());
      chk("t6_pre_from", 32'(from_core_level), q_b.size());
      #2 ap_rst = 1'b1;
      #1;
      chk("t6_to_level", 32'(to_core_level), 32'd0);
      chk("t6_from_level", 32'(from_core_level), 32'd0);
      chk("t6_core_rst", 32'(core_rst), 32'd1);
      chk("t6_empty_n", 32'(in_r_empty_n), 32'd0);
      chk("t6_r_empty", 32'(user_r_data_empty), 32'd1);
      q_a.delete();
      q_b.delete();
      #2 ap_rst = 1'b0;
      tick();
      chk("t6_after_rst", 32'(core_rst), 32'd0);
      chk("t6_after_empty_n", 32'(in_r_empty_n), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
